axis_requantizer: RTL and testbench
===================================

Name: axis_requantizer

Overview:
Parametrised, pipelined AXI-Stream requantizer that turns wide signed filter-accumulator samples into narrow output codes for the DAC/back-end. Per-channel arithmetic right shift, optional round-half-up, saturating clamp, and selectable offset-binary or two's-complement output. Handles full ready/valid backpressure, propagates tlast, and keeps a saturation-event counter. Sits directly after the FIR stage and replaces the combinational shift/clamp glue.

Parameters:
IN_WIDTH, 64, signed input sample width per channel
OUT_WIDTH, 8, output code width per channel (2..IN_WIDTH-1)
NUM_CH, 1, channels packed side by side in tdata (channel 0 in LSBs)
SHIFT_W, 6, width of the shift control
SAT_CNT_W, 16, width of the saturation counter

Ports:
s00_axis_aclk  in  1  sole clock
s00_axis_areset  in  1  reset, asynchronous, active-high
s00_axis_tdata  in  NUM_CH*IN_WIDTH  signed input samples
s00_axis_tvalid  in  1  input valid
s00_axis_tlast  in  1  input end-of-packet
s00_axis_tready  out  1  input ready
m00_axis_tdata  out  NUM_CH*OUT_WIDTH  output codes
m00_axis_tvalid  out  1  output valid
m00_axis_tlast  out  1  output end-of-packet
m00_axis_tready  in  1  downstream ready
shift  in  SHIFT_W  right-shift amount, unsigned
round_en  in  1  1 = round half up before shifting
offset_bin  in  1  1 = offset-binary output, 0 = two's complement
sat_clear  in  1  synchronous clear of sat_count
sat_count  out  SAT_CNT_W  count of output beats with any saturated channel

Behaviour:
- Clock and reset: one clock, s00_axis_aclk. s00_axis_areset is asynchronous and active-high.
- Reset values: both stage valids 0, m00_axis_tvalid 0, m00_axis_tdata 0, m00_axis_tlast 0, sat_count 0. Reset asserted mid-stream discards in-flight beats. s00_axis_tready is 1 after reset release.
- Pipeline: two registered stages. S1 registers the shifted/rounded value plus tlast. S2 registers the clamped/encoded code, per-channel saturation flags, and tlast, and drives m00.
- Latency: 2 cycles from input handshake to m00_axis_tvalid when there is no backpressure. Throughput is 1 beat/cycle.
- Advance rules: S2 loads when (!S2.valid || m00_axis_tready). S1 loads when (!S1.valid || S2 loads). s00_axis_tready = !S1.valid || S2 loads. No beat is dropped or duplicated. m00 data and last stay stable while tvalid=1 and tready=0.
- Sampling: shift, round_en and offset_bin are sampled at the input handshake and carried with the beat. Changing them mid-stream affects only later beats.
- Arithmetic, per channel, signed, using IN_WIDTH+1 internal bits so rounding cannot overflow:
  - If round_en=1 and 0 < shift < IN_WIDTH: v = (x + 2^(shift-1)) >>> shift.
  - Otherwise: v = x >>> shift.
  - If shift >= IN_WIDTH: v = 0 when x >= 0, and v = -1 when x < 0. No rounding is applied.
- Clamp: v is limited to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The channel's sat flag is set when clamping changes v.
- Encode: when offset_bin=1, the code is the clamped value + 2^(OUT_WIDTH-1) (MSB inverted), giving range 0..2^OUT_WIDTH-1. When offset_bin=0, the code is the clamped value in two's complement.
- sat_count:
  - Increments by 1 on each m00 handshake where any channel's sat flag is set.
  - Holds at all-ones; it does not wrap.
  - sat_clear=1 sets it to 0 on the next edge. Clear wins over a simultaneous increment.

Decomposition:
- Shared package requant_pkg holds:
  - the rounding-bias and clamp-limit constant functions, parameterised on OUT_WIDTH and the shift value;
  - the S1/S2 stage record typedef {valid, last, data, sat}.
- Sub-module requant_lane: one channel, purely combinational shift/round/clamp/encode, output sat flag. The top instantiates it NUM_CH times in a generate loop. All handshake, registers and the counter stay in the top.

Test Plan:
- OUT_WIDTH=8, offset_bin=1, round_en=0, shift=4, input 2048 -> code 0xFF, sat flag set, sat_count=1. Input -32 -> 0x7E, sat_count unchanged.
- shift=4, input 24, offset_bin=1: round_en=1 -> 0x82; round_en=0 -> 0x81. Input -8 with round_en=1 -> 0x80.
- offset_bin=0, shift=0, inputs -1000 / 1000 / -5 -> 0x80 (sat), 0x7F (sat), 0xFB. shift=63 with input -1 -> 0xFF; with input 5 -> 0x00.
- Stream of 6 beats with tlast on beat 6, m00_axis_tready held low for cycles 3..8:
  - s00_axis_tready drops after 2 beats are buffered;
  - m00 data stays stable while stalled;
  - all 6 codes arrive in order with tlast only on the 6th;
  - first output appears 2 cycles after the first handshake.
- NUM_CH=2, SAT_CNT_W=2, lanes {3000, 16}, shift=4: lane1 saturates and lane0 does not, giving {0xFF, 0x81}. 5 such beats -> sat_count holds at 3. sat_clear in the same cycle as a saturating handshake -> sat_count=0.
- Assert s00_axis_areset asynchronously (between edges) with both stages full -> m00_axis_tvalid and tdata go to 0 immediately. After release, a fresh beat comes out 2 cycles after its handshake.

Source files
------------

// File: rtl/requant_pkg.sv
// Shared constants and stage records for the AXI-Stream requantizer.
// Constant helpers are computed wide and narrowed by the caller with a size cast.
package requant_pkg;

    localparam int MAX_W = 256;

    // Handshake part of a pipeline stage record; the top adds data and sat.
    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctl_t;

    // 2^(sh-1), the half-LSB bias added before a rounding right shift.
    function automatic logic signed [MAX_W-1:0] round_bias(input int unsigned sh);
        return (sh == 0) ? '0 : (MAX_W'(1) << (sh - 1));
    endfunction

    function automatic logic signed [MAX_W-1:0] clamp_hi(input int unsigned out_w);
        return (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic signed [MAX_W-1:0] clamp_lo(input int unsigned out_w);
        return -(MAX_W'(1) << (out_w - 1));
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One channel of the requantizer: shift/round front half feeding stage 1,
// clamp/encode back half fed from stage 1. Purely combinational.
module requant_lane
    import requant_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 6
) (
    input  logic signed [IN_WIDTH-1:0] x,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       round_en,
    output logic signed [IN_WIDTH:0]   v,
    input  logic signed [IN_WIDTH:0]   v_reg,
    input  logic                       offset_bin,
    output logic [OUT_WIDTH-1:0]       code,
    output logic                       sat
);

    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] HI = RW'(clamp_hi(OUT_WIDTH));
    localparam logic signed [RW-1:0] LO = RW'(clamp_lo(OUT_WIDTH));

    logic signed [RW-1:0] x_ext;
    logic signed [RW-1:0] bias;
    logic signed [RW-1:0] clamped;
    int unsigned          sh;

    // One extra bit of headroom so x + bias cannot wrap.
    assign x_ext = RW'(x);
    assign sh    = 32'(shift);
    assign bias  = RW'(round_bias(sh));

    // NOTE: every output of an always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        v = x_ext >>> shift;
        if (sh >= IN_WIDTH) begin
            v = x_ext[RW-1] ? '1 : '0;
        end else if (round_en && sh != 0) begin
            v = (x_ext + bias) >>> shift;
        end
    end

    always_comb begin
        clamped = v_reg;
        sat     = 1'b0;
        if (v_reg > HI) begin
            clamped = HI;
            sat     = 1'b1;
        end else if (v_reg < LO) begin
            clamped = LO;
            sat     = 1'b1;
        end
        code = OUT_WIDTH'(clamped);
        if (offset_bin) begin
            code[OUT_WIDTH-1] = ~code[OUT_WIDTH-1];
        end
    end

endmodule

// File: rtl/axis_requantizer.sv
// Two-stage AXI-Stream requantizer: S1 holds shifted values, S2 holds clamped
// codes and drives m00. Full backpressure plus a saturating event counter.
module axis_requantizer
    import requant_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_CH    = 1,
    parameter int SHIFT_W   = 6,
    parameter int SAT_CNT_W = 16
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_areset,
    input  logic [NUM_CH*IN_WIDTH-1:0]    s00_axis_tdata,
    input  logic                          s00_axis_tvalid,
    input  logic                          s00_axis_tlast,
    output logic                          s00_axis_tready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   m00_axis_tdata,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    input  logic [SHIFT_W-1:0]            shift,
    input  logic                          round_en,
    input  logic                          offset_bin,
    input  logic                          sat_clear,
    output logic [SAT_CNT_W-1:0]          sat_count
);

    localparam int RW = IN_WIDTH + 1;

    typedef struct packed {
        stage_ctl_t            ctl;
        logic                  offset_bin;
        logic [NUM_CH*RW-1:0]  data;
    } s1_t;

    typedef struct packed {
        stage_ctl_t                  ctl;
        logic [NUM_CH*OUT_WIDTH-1:0] data;
        logic [NUM_CH-1:0]           sat;
    } s2_t;

    s1_t s1;
    s2_t s2;

    logic                        s1_load;
    logic                        s2_load;
    logic [NUM_CH*RW-1:0]        v_next;
    logic [NUM_CH*OUT_WIDTH-1:0] code_next;
    logic [NUM_CH-1:0]           sat_next;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        requant_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT_W   (SHIFT_W)
        ) u_lane (
            .x          (s00_axis_tdata[ch*IN_WIDTH +: IN_WIDTH]),
            .shift      (shift),
            .round_en   (round_en),
            .v          (v_next[ch*RW +: RW]),
            .v_reg      (s1.data[ch*RW +: RW]),
            .offset_bin (s1.offset_bin),
            .code       (code_next[ch*OUT_WIDTH +: OUT_WIDTH]),
            .sat        (sat_next[ch])
        );
    end

    assign s2_load         = !s2.ctl.valid || m00_axis_tready;
    assign s1_load         = !s1.ctl.valid || s2_load;
    assign s00_axis_tready = s1_load;

    assign m00_axis_tvalid = s2.ctl.valid;
    assign m00_axis_tlast  = s2.ctl.last;
    assign m00_axis_tdata  = s2.data;

    // NOTE: data registers are reset along with valid because m00_axis_tdata must read 0 during reset.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (s1_load) begin
                s1.ctl.valid  <= s00_axis_tvalid;
                s1.ctl.last   <= s00_axis_tlast;
                s1.offset_bin <= offset_bin;
                s1.data       <= v_next;
            end
            if (s2_load) begin
                s2.ctl  <= s1.ctl;
                s2.data <= code_next;
                s2.sat  <= sat_next;
            end
        end
    end

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (m00_axis_tvalid && m00_axis_tready && (|s2.sat) && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_requantizer.sv
// Self-checking bench for axis_requantizer: a behavioural scoreboard for the
// default configuration plus directed literal checks, and a 2-lane instance.
module tb_axis_requantizer;

    int vectors     = 0;
    int miscompares = 0;
    int out_beats   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (64 -> 8 bits, one channel, 16-bit counter)
    logic [63:0] s_tdata  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [5:0]  shift    = '0;
    logic        round_en = 1'b0;
    logic        offset_bin = 1'b1;
    logic        sat_clear  = 1'b0;
    logic [15:0] sat_count;

    // Instance B: two lanes, 2-bit counter
    logic [127:0] b_s_tdata  = '0;
    logic         b_s_tvalid = 1'b0;
    logic         b_s_tready;
    logic [15:0]  b_m_tdata;
    logic         b_m_tvalid;
    logic         b_m_tlast;
    logic         b_m_tready = 1'b1;
    logic         b_sat_clear = 1'b0;
    logic [1:0]   b_sat_count;

    axis_requantizer dut_a (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .shift           (shift),
        .round_en        (round_en),
        .offset_bin      (offset_bin),
        .sat_clear       (sat_clear),
        .sat_count       (sat_count)
    );

    axis_requantizer #(.NUM_CH(2), .SAT_CNT_W(2)) dut_b (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (b_s_tdata),
        .s00_axis_tvalid (b_s_tvalid),
        .s00_axis_tlast  (1'b0),
        .s00_axis_tready (b_s_tready),
        .m00_axis_tdata  (b_m_tdata),
        .m00_axis_tvalid (b_m_tvalid),
        .m00_axis_tlast  (b_m_tlast),
        .m00_axis_tready (b_m_tready),
        .shift           (6'd4),
        .round_en        (1'b0),
        .offset_bin      (1'b1),
        .sat_clear       (b_sat_clear),
        .sat_count       (b_sat_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic for OUT_WIDTH=8: wide floor-shift, clamp, encode.
    function automatic void model(input logic signed [63:0] x, input int sh, input bit rnd,
                                  input bit ob, output logic [7:0] code, output bit sat);
        logic signed [127:0] v;
        longint c;
        v = 128'(x);
        if (sh >= 64) begin
            v = (x < 0) ? -128'sd1 : 128'sd0;
        end else begin
            if (rnd && sh > 0) v = v + (128'sd1 <<< (sh - 1));
            v = v >>> sh;
        end
        sat = 1'b1;
        if (v > 127)       c = 127;
        else if (v < -128) c = -128;
        else begin
            c   = longint'(v);
            sat = 1'b0;
        end
        code = 8'(ob ? c + 128 : c);
    endfunction

    typedef struct {
        logic [7:0] code;
        logic       last;
        bit         sat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt   = '0;
    bit          stalled   = 1'b0;
    logic [7:0]  hold_data = '0;
    logic        hold_last = 1'b0;

    // Scoreboard for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
            stalled = 1'b0;
        end else begin
            check("sat_count", sat_count, exp_cnt);
            if (stalled) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, hold_data);
                check("stall_last", m_tlast, hold_last);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_beat: got unexpected beat %0h, expected none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, e.code);
                    check("out_last", m_tlast, e.last);
                    out_beats++;
                    if (e.sat && exp_cnt != '1) exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (sat_clear) exp_cnt = '0;
            stalled   = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_last = m_tlast;
            if (s_tvalid && s_tready) begin
                model($signed(s_tdata), int'(shift), round_en, offset_bin, e.code, e.sat);
                e.last = s_tlast;
                exp_q.push_back(e);
            end
        end
    end

    // Present one beat on instance A and hold it until accepted; returns at posedge+1.
    task automatic send(input longint x, input bit last, input logic [5:0] sh,
                        input bit rnd, input bit ob);
        int n = 0;
        s_tdata    = x;
        s_tlast    = last;
        shift      = sh;
        round_en   = rnd;
        offset_bin = ob;
        s_tvalid   = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: s00_axis_tready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic run_one(input string name, input longint x, input logic [5:0] sh,
                           input bit rnd, input bit ob, input logic [7:0] exp_code);
        int n = 0;
        @(posedge clk);
        #1;
        send(x, 1'b0, sh, rnd, ob);
        @(negedge clk);
        while (!m_tvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, "_valid"}, m_tvalid, 1);
        check(name, m_tdata, exp_code);
    endtask

    longint stream_x[6] = '{40, -40, 100, -100, 600, 4};

    initial begin
        int base;
        int n;
        #12 rst = 1'b0;
        @(negedge clk);
        check("reset_tready", s_tready, 1);
        check("reset_tvalid", m_tvalid, 0);
        check("reset_tdata", m_tdata, 0);
        check("reset_tlast", m_tlast, 0);

        // Offset-binary saturation and a negative value
        run_one("sat_2048", 2048, 6'd4, 1'b0, 1'b1, 8'hFF);
        run_one("neg_32", -32, 6'd4, 1'b0, 1'b1, 8'h7E);
        @(negedge clk);
        check("sat_count_one", sat_count, 1);

        // Rounding
        run_one("round_24", 24, 6'd4, 1'b1, 1'b1, 8'h82);
        run_one("trunc_24", 24, 6'd4, 1'b0, 1'b1, 8'h81);
        run_one("round_m8", -8, 6'd4, 1'b1, 1'b1, 8'h80);

        // Two's complement clamp and extreme shift
        run_one("clip_neg", -1000, 6'd0, 1'b0, 1'b0, 8'h80);
        run_one("clip_pos", 1000, 6'd0, 1'b0, 1'b0, 8'h7F);
        run_one("m5", -5, 6'd0, 1'b0, 1'b0, 8'hFB);
        run_one("sh63_m1", -1, 6'd63, 1'b0, 1'b0, 8'hFF);
        run_one("sh63_p5", 5, 6'd63, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("sat_count_three", sat_count, 3);

        // 6-beat packet with downstream stalled in cycles 3..8
        @(posedge clk);
        #1;
        base = out_beats;
        fork
            begin
                for (int i = 0; i < 6; i++) send(stream_x[i], i == 5, 6'd2, 1'b0, 1'b1);
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    m_tready = !(c >= 3 && c <= 8);
                    @(negedge clk);
                    if (c == 2) check("lat_not_yet", m_tvalid, 0);
                    if (c == 3) begin
                        check("lat_first", m_tvalid, 1);
                        check("stream_first", m_tdata, 8'h8A);
                        check("bp_tready", s_tready, 0);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        n = 0;
        while (out_beats - base < 6 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("stream_count", out_beats - base, 6);

        // Two-lane instance: lane1 saturates, lane0 does not
        b_s_tdata = {64'sd3000, 64'sd16};
        @(posedge clk);
        #1;
        b_s_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 5) check("b_tready", b_s_tready, 1);
            if (i >= 2 && i < 7) begin
                check("b_valid", b_m_tvalid, 1);
                check("b_data", b_m_tdata, 16'hFF81);
                check("b_last", b_m_tlast, 0);
            end
            @(posedge clk);
            #1;
            if (i == 4) b_s_tvalid = 1'b0;
        end
        check("b_sat_hold", b_sat_count, 3);
        b_sat_clear = 1'b1;
        @(posedge clk);
        #1;
        b_sat_clear = 1'b0;
        check("b_clear", b_sat_count, 0);
        b_m_tready = 1'b0;
        b_s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        b_s_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_stalled_valid", b_m_tvalid, 1);
        b_m_tready  = 1'b1;
        b_sat_clear = 1'b1;
        @(posedge clk);
        #1;
        b_sat_clear = 1'b0;
        check("b_clear_wins", b_sat_count, 0);
        check("b_consumed", b_m_tvalid, 0);

        // Asynchronous reset with both stages full
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        send(77, 1'b0, 6'd0, 1'b0, 1'b1);
        send(78, 1'b0, 6'd0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_tvalid", m_tvalid, 0);
        check("arst_tdata", m_tdata, 0);
        check("arst_tlast", m_tlast, 0);
        check("arst_sat", sat_count, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("post_reset_tready", s_tready, 1);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        send(300, 1'b1, 6'd4, 1'b1, 1'b1);
        @(negedge clk);
        check("post_reset_lat1", m_tvalid, 0);
        @(negedge clk);
        check("post_reset_lat2", m_tvalid, 1);
        check("post_reset_data", m_tdata, 8'h93);
        check("post_reset_last", m_tlast, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
